detec_col_multi: RTL and testbench

//  Parametrised successor of the single-enemy collision detector. Checks one

---
 rtl/detec_col_multi.sv | 149 ++++++++++++++
 tb/tb_detec_col_multi.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/detec_col_multi.sv
// Missile-vs-N-enemy collision detector: per-enemy HP/alive tracking, one hit per missile flight.
// Hit, kill and wave-clear outputs are registered one cycle after the sampled inputs; no backpressure.
module detec_col_multi #(
  parameter int N_ENEMY    = 8,
  parameter int HALF_WIDTH = 25,
  parameter int HEIGHT     = 50,
  parameter int HP         = 2,
  parameter int IDX_W      = 4
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic [10:0]            xpos_missile,
  input  logic [10:0]            ypos_missile,
  input  logic                   on_missile,
  input  logic                   level_change,
  input  logic [11*N_ENEMY-1:0]  xpos_enemy,
  input  logic [11*N_ENEMY-1:0]  ypos_enemy,
  output logic [N_ENEMY-1:0]     on_out,
  output logic                   missile_kill,
  output logic                   hit_pulse,
  output logic [IDX_W-1:0]       hit_idx,
  output logic                   kill_pulse,
  output logic [7:0]             kill_count,
  output logic                   all_dead
);

  localparam logic [2:0] HP_L = 3'(HP);

  typedef enum logic {ARMED = 1'b0, SPENT = 1'b1} state_t;

  state_t             r_state;
  logic [2:0]         r_hp [N_ENEMY];
  logic [N_ENEMY-1:0] r_on;
  logic               r_mk;
  logic               r_hit;
  logic [IDX_W-1:0]   r_idx;
  logic               r_kill;
  logic [7:0]         r_kc;
  logic               r_all_dead;

  logic [11:0]        w_xm;
  logic [11:0]        w_ym;
  logic [N_ENEMY-1:0] w_ovl;
  logic [N_ENEMY-1:0] w_req;
  logic [N_ENEMY-1:0] w_oh;
  logic [N_ENEMY-1:0] w_kill_mask;
  logic [N_ENEMY-1:0] w_on_after_hit;
  logic               w_cand_vld;
  logic               w_hit;
  logic               w_last_hp;
  logic [IDX_W-1:0]   w_cand_idx;

  // 12-bit compares so enemy x + HALF_WIDTH and y + HEIGHT never wrap
  assign w_xm = {1'b0, xpos_missile};
  assign w_ym = {1'b0, ypos_missile};

  for (genvar g = 0; g < N_ENEMY; g++) begin : g_ovl
    logic [11:0] w_xe;
    logic [11:0] w_ye;
    logic [11:0] w_xlo;
    logic [11:0] w_xhi;
    logic [11:0] w_yhi;
    assign w_xe     = {1'b0, xpos_enemy[11*g +: 11]};
    assign w_ye     = {1'b0, ypos_enemy[11*g +: 11]};
    assign w_xlo    = (w_xe < 12'(HALF_WIDTH)) ? 12'd0 : w_xe - 12'(HALF_WIDTH);
    assign w_xhi    = w_xe + 12'(HALF_WIDTH);
    assign w_yhi    = w_ye + 12'(HEIGHT);
    assign w_ovl[g] = (w_xm >= w_xlo) && (w_xm <= w_xhi) &&
                      (w_ym >= w_ye)  && (w_ym <= w_yhi);
  end

  // Lowest-index live overlapping enemy wins; isolate it as a one-hot mask
  assign w_req      = w_ovl & r_on;
  assign w_oh       = w_req & (~w_req + N_ENEMY'(1));
  assign w_cand_vld = |w_req;

  always_comb begin
    w_cand_idx = '0;
    w_last_hp  = 1'b0;
    for (int i = 0; i < N_ENEMY; i++) begin
      if (w_oh[i]) begin
        w_cand_idx = IDX_W'(i);
        w_last_hp  = (r_hp[i] == 3'd1);
      end
    end
  end

  assign w_hit          = (r_state == ARMED) && on_missile && w_cand_vld && !level_change;
  assign w_kill_mask    = (w_hit && w_last_hp) ? w_oh : '0;
  assign w_on_after_hit = r_on & ~w_kill_mask;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_state    <= ARMED;
      r_on       <= '1;
      for (int i = 0; i < N_ENEMY; i++) r_hp[i] <= HP_L;
      r_mk       <= 1'b0;
      r_hit      <= 1'b0;
      r_idx      <= '0;
      r_kill     <= 1'b0;
      r_kc       <= 8'd0;
      r_all_dead <= 1'b0;
    end else begin
      r_mk   <= 1'b0;
      r_hit  <= 1'b0;
      r_kill <= 1'b0;
      if (level_change) begin
        // New wave: any coincident hit is dropped, an in-flight missile stays spent
        r_on       <= '1;
        for (int i = 0; i < N_ENEMY; i++) r_hp[i] <= HP_L;
        r_all_dead <= 1'b0;
        r_state    <= on_missile ? SPENT : ARMED;
      end else begin
        case (r_state)
          ARMED: begin
            if (w_hit) begin
              r_state <= SPENT;
              r_mk    <= 1'b1;
              r_hit   <= 1'b1;
              r_idx   <= w_cand_idx;
              for (int i = 0; i < N_ENEMY; i++) begin
                if (w_oh[i]) r_hp[i] <= r_hp[i] - 3'd1;
              end
              if (w_last_hp) begin
                r_kill <= 1'b1;
                if (r_kc != 8'hFF) r_kc <= r_kc + 8'd1;
              end
              r_on       <= w_on_after_hit;
              r_all_dead <= (w_on_after_hit == '0);
            end
          end
          SPENT: begin
            if (!on_missile) r_state <= ARMED;
          end
          default: r_state <= ARMED;
        endcase
      end
    end
  end

  assign on_out       = r_on;
  assign missile_kill = r_mk;
  assign hit_pulse    = r_hit;
  assign hit_idx      = r_idx;
  assign kill_pulse   = r_kill;
  assign kill_count   = r_kc;
  assign all_dead     = r_all_dead;

endmodule

// File: tb/tb_detec_col_multi.sv
// Bench for detec_col_multi: directed table, corner-case sequences and random traffic vs a reference model.
module tb_detec_col_multi;

  localparam int N   = 8;
  localparam int HW  = 25;
  localparam int HT  = 50;
  localparam int HPV = 2;
  localparam int IW  = 4;

  logic            pclk = 1'b0;
  logic            rst;
  logic [10:0]     xm, ym;
  logic            onm, lvl;
  logic [10:0]     ex [N];
  logic [10:0]     ey [N];
  logic [11*N-1:0] xpos_enemy, ypos_enemy;
  logic [N-1:0]    on_out;
  logic            missile_kill, hit_pulse, kill_pulse, all_dead;
  logic [IW-1:0]   hit_idx;
  logic [7:0]      kill_count;

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < N; g++) begin : g_pk
    assign xpos_enemy[11*g +: 11] = ex[g];
    assign ypos_enemy[11*g +: 11] = ey[g];
  end

  detec_col_multi #(.N_ENEMY(N), .HALF_WIDTH(HW), .HEIGHT(HT), .HP(HPV), .IDX_W(IW)) dut (
    .pclk(pclk), .rst(rst),
    .xpos_missile(xm), .ypos_missile(ym),
    .on_missile(onm), .level_change(lvl),
    .xpos_enemy(xpos_enemy), .ypos_enemy(ypos_enemy),
    .on_out(on_out), .missile_kill(missile_kill), .hit_pulse(hit_pulse),
    .hit_idx(hit_idx), .kill_pulse(kill_pulse), .kill_count(kill_count),
    .all_dead(all_dead)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: game rules in plain integers
  int  m_hp [N];
  bit  m_alive [N];
  bit  m_armed;
  int  m_kc;
  bit  e_hit, e_kill;
  int  e_idx;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_hp[i] = HPV;
      m_alive[i] = 1'b1;
    end
    m_armed = 1'b1;
    m_kc = 0;
    e_hit = 1'b0;
    e_kill = 1'b0;
    e_idx = 0;
  endtask

  function automatic bit overlaps(input int i);
    int x, y, mx, my;
    x = int'(ex[i]);
    y = int'(ey[i]);
    mx = int'(xm);
    my = int'(ym);
    return (mx >= x - HW) && (mx <= x + HW) && (my >= y) && (my <= y + HT);
  endfunction

  function automatic int model_on();
    int v;
    v = 0;
    for (int i = 0; i < N; i++) if (m_alive[i]) v += (1 << i);
    return v;
  endfunction

  task automatic model_step();
    int cand;
    cand = -1;
    for (int i = 0; i < N; i++) if (cand < 0 && m_alive[i] && overlaps(i)) cand = i;
    e_hit = 1'b0;
    e_kill = 1'b0;
    if (lvl) begin
      for (int i = 0; i < N; i++) begin
        m_alive[i] = 1'b1;
        m_hp[i] = HPV;
      end
      m_armed = !onm;
    end else if (!onm) begin
      m_armed = 1'b1;
    end else if (m_armed && cand >= 0) begin
      e_hit = 1'b1;
      e_idx = cand;
      m_hp[cand]--;
      if (m_hp[cand] == 0) begin
        m_alive[cand] = 1'b0;
        e_kill = 1'b1;
        if (m_kc < 255) m_kc++;
      end
      m_armed = 1'b0;
    end
  endtask

  task automatic compare_model();
    chk("on_out", int'(on_out), model_on());
    chk("hit_pulse", int'(hit_pulse), int'(e_hit));
    chk("missile_kill", int'(missile_kill), int'(e_hit));
    chk("kill_pulse", int'(kill_pulse), int'(e_kill));
    chk("kill_count", int'(kill_count), m_kc);
    chk("all_dead", int'(all_dead), int'(model_on() == 0));
    if (e_hit) chk("hit_idx", int'(hit_idx), e_idx);
  endtask

  // Inputs are already driven; advance one edge and check
  task automatic cycle();
    model_step();
    @(posedge pclk);
    #1;
    compare_model();
  endtask

  task automatic set_default_pos();
    for (int i = 0; i < N; i++) begin
      ex[i] = 11'(100 + 200 * i);
      ey[i] = 11'd200;
    end
  endtask

  task automatic drive(input int x, input int y, input bit o, input bit l);
    xm = 11'(x);
    ym = 11'(y);
    onm = o;
    lvl = l;
  endtask

  typedef struct {
    int xm; int ym; bit onm; bit lvl;
    bit e_hit; int e_idx; bit e_kill; int e_kc; int e_on;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int mk_cnt;
    tbl[0]  = '{75,  200, 1'b1, 1'b0, 1'b1, 0, 1'b0, 0, 255};
    tbl[1]  = '{75,  200, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 255};
    tbl[2]  = '{75,  200, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 255};
    tbl[3]  = '{0,   0,   1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 255};
    tbl[4]  = '{74,  200, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 255};
    tbl[5]  = '{100, 251, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 255};
    tbl[6]  = '{126, 200, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 255};
    tbl[7]  = '{100, 199, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 255};
    tbl[8]  = '{125, 250, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1, 254};
    tbl[9]  = '{0,   0,   1'b0, 1'b0, 1'b0, 0, 1'b0, 1, 254};
    tbl[10] = '{100, 225, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1, 254};
    tbl[11] = '{275, 250, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1, 254};
    tbl[12] = '{0,   0,   1'b0, 1'b0, 1'b0, 0, 1'b0, 1, 254};

    rst = 1'b0;
    drive(0, 0, 1'b0, 1'b0);
    set_default_pos();
    model_reset();
    repeat (2) @(posedge pclk);
    #1;
    compare_model();
    chk("rst_on_out", int'(on_out), 255);
    chk("rst_hit_idx", int'(hit_idx), 0);
    rst = 1'b1;

    for (int r = 0; r < 13; r++) begin
      drive(tbl[r].xm, tbl[r].ym, tbl[r].onm, tbl[r].lvl);
      cycle();
      chk("tbl_hit", int'(hit_pulse), int'(tbl[r].e_hit));
      if (tbl[r].e_hit) chk("tbl_idx", int'(hit_idx), tbl[r].e_idx);
      chk("tbl_kill", int'(kill_pulse), int'(tbl[r].e_kill));
      chk("tbl_kc", int'(kill_count), tbl[r].e_kc);
      chk("tbl_on", int'(on_out), tbl[r].e_on);
    end

    // Enemies 2 and 5 stacked: only the lower index is hit, once
    ex[2] = 11'd800; ey[2] = 11'd600;
    ex[5] = 11'd800; ey[5] = 11'd600;
    drive(800, 620, 1'b1, 1'b0);
    cycle();
    chk("stack_hit", int'(hit_pulse), 1);
    chk("stack_idx", int'(hit_idx), 2);
    mk_cnt = int'(missile_kill);
    repeat (3) begin
      cycle();
      mk_cnt += int'(missile_kill);
    end
    chk("stack_single_mk", mk_cnt, 1);
    drive(0, 0, 1'b0, 1'b0);
    cycle();
    ex[2] = 11'd500; ey[2] = 11'd200;
    drive(800, 620, 1'b1, 1'b0);
    cycle();
    chk("e5_idx", int'(hit_idx), 5);
    chk("e5_full_hp_no_kill", int'(kill_pulse), 0);
    drive(0, 0, 1'b0, 1'b0);
    cycle();

    // Lower x bound clamps to 0
    ex[3] = 11'd10;
    drive(0, 200, 1'b1, 1'b0);
    cycle();
    chk("clamp_hit", int'(hit_pulse), 1);
    chk("clamp_idx", int'(hit_idx), 3);
    drive(0, 0, 1'b0, 1'b0);
    cycle();
    ex[3] = 11'd700;

    // level_change coincident with an overlap
    drive(900, 220, 1'b1, 1'b1);
    cycle();
    chk("lvl_no_hit", int'(hit_pulse), 0);
    chk("lvl_revive", int'(on_out), 255);
    drive(900, 220, 1'b1, 1'b0);
    cycle();
    chk("lvl_spent", int'(hit_pulse), 0);
    drive(0, 0, 1'b0, 1'b0);
    cycle();
    drive(900, 220, 1'b1, 1'b0);
    cycle();
    chk("rearm_idx", int'(hit_idx), 4);
    drive(0, 0, 1'b0, 1'b0);
    cycle();

    // Wipe the wave
    set_default_pos();
    for (int i = 0; i < N; i++) begin
      for (int guard = 0; guard < 10 && m_alive[i]; guard++) begin
        drive(int'(ex[i]), int'(ey[i]) + 10, 1'b1, 1'b0);
        cycle();
        if (e_kill && i == N - 1) begin
          chk("all_dead_final", int'(all_dead), 1);
          chk("on_out_final", int'(on_out), 0);
        end
        drive(0, 0, 1'b0, 1'b0);
        cycle();
      end
    end
    chk("wave_kc", int'(kill_count), 9);
    drive(0, 0, 1'b0, 1'b1);
    cycle();
    chk("new_wave_on", int'(on_out), 255);
    chk("new_wave_all_dead", int'(all_dead), 0);
    chk("new_wave_kc", int'(kill_count), 9);
    lvl = 1'b0;

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        ex[i] = 11'($urandom_range(0, 150));
        ey[i] = 11'($urandom_range(0, 150));
      end
      xm = 11'($urandom_range(0, 200));
      ym = 11'($urandom_range(0, 200));
      if ($urandom_range(0, 3) == 0) onm = ~onm;
      lvl = ($urandom_range(0, 31) == 0);
      cycle();
    end

    // Reset mid-flight
    set_default_pos();
    drive(100, 210, 1'b1, 1'b0);
    cycle();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_kc", int'(kill_count), 0);
    chk("arst_on", int'(on_out), 255);
    chk("arst_hit", int'(hit_pulse), 0);
    chk("arst_mk", int'(missile_kill), 0);
    chk("arst_all_dead", int'(all_dead), 0);
    model_reset();
    @(posedge pclk);
    #1;
    rst = 1'b1;
    cycle();
    chk("post_rst_hit", int'(hit_pulse), 1);
    cycle();
    drive(0, 0, 1'b0, 1'b0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
